muldiv_sequencer: RTL and testbench

- Iterative RV32M multiply/divide unit for the execute stage.
- Time-shares one 33-bit add/sub datapath over XLEN iterations to implement all eight M-extension ops.
- Uses a start/busy/done handshake; the pipeline stalls EX while busy is high.
- Replaces a combinational multiplier/divider with a small sequenced datapath.

---
 rtl/muldiv_sequencer_pkg.sv | 33 +++
 rtl/muldiv_sequencer_if.sv | 31 +++
 rtl/muldiv_addsub.sv | 21 ++
 rtl/muldiv_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_sequencer_pkg
//  Purpose  : Shared encodings and constants for the iterative RV32M unit
//  Revision : 1.0  initial release
// ============================================================================
package muldiv_sequencer_pkg;

    localparam int XLEN_DEF = 32;

    // funct3 encodings of the M extension
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    // Quotient returned for a zero divisor
    localparam logic [XLEN_DEF-1:0] DIV0_QUOT = '1;

endpackage
`default_nettype wire

// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_sequencer_if
//  Purpose  : start/busy/done request bus between EX stage and muldiv unit
//  Revision : 1.0  initial release
// ============================================================================
interface muldiv_sequencer_if
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, rs1, rs2, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, rs1, rs2, flush,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_addsub
//  Purpose  : Combinational adder/subtractor shared by mul and div iterations
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_addsub #(
    parameter int W = 33
) (
    input  wire logic [W-1:0] a_i,
    input  wire logic [W-1:0] b_i,
    input  wire logic         sub_i,   // 1: a - b (invert b, carry-in 1)
    output logic      [W-1:0] sum_o,
    output logic              cout_o   // for subtraction: 1 means no borrow
);
    logic [W-1:0] b_eff;

    assign b_eff           = sub_i ? ~b_i : b_i;
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{W{1'b0}}, sub_i};
endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_sequencer
//  Purpose  : Iterative RV32M multiply/divide, one add/sub step per cycle
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    muldiv_sequencer_if.slave  mif
);
    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic              a_neg_q, a_neg_d, b_neg_q, b_neg_d, div0_q, div0_d;
    logic [XLEN-1:0]   mag_a_q, mag_a_d, mag_b_q, mag_b_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;   // mul: {hi,lo} product; div: {rem,quot}
    logic [XLEN-1:0]   result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d, done_q, done_d;

    logic [XLEN:0]     add_a, add_b, add_sum;
    logic              add_sub, add_cout;
    op_e               req_op;
    logic              req_a_neg, req_b_neg;
    logic [2*XLEN-1:0] prod, prod_neg;
    logic [XLEN-1:0]   fin_val;
    logic              sgn_diff;

    // Steer the shared adder: add |A| into hi for mul, trial-subtract |B| for div
    always_comb begin
        if (op_q[2]) begin
            add_a   = {hi_q, lo_q[XLEN-1]};
            add_b   = {1'b0, mag_b_q};
            add_sub = 1'b1;
        end else begin
            add_a   = {1'b0, hi_q};
            add_b   = lo_q[0] ? {1'b0, mag_a_q} : '0;
            add_sub = 1'b0;
        end
    end

    muldiv_addsub #(.W(XLEN + 1)) u_addsub (
        .a_i    (add_a),
        .b_i    (add_b),
        .sub_i  (add_sub),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // Decode sign treatment of an incoming request
    always_comb begin
        req_op    = op_e'(mif.op);
        req_a_neg = mif.rs1[XLEN-1] && (req_op == OP_MULH || req_op == OP_MULHSU ||
                                        req_op == OP_DIV  || req_op == OP_REM);
        req_b_neg = mif.rs2[XLEN-1] && (req_op == OP_MULH || req_op == OP_DIV ||
                                        req_op == OP_REM);
    end

    // Sign-fix the magnitude result; 64-bit negate so MULH* high halves are exact
    always_comb begin
        sgn_diff = a_neg_q ^ b_neg_q;
        prod     = {hi_q, lo_q};
        prod_neg = -prod;
        case (op_q)
            OP_MUL:                       fin_val = sgn_diff ? prod_neg[XLEN-1:0] : lo_q;
            OP_MULH, OP_MULHSU, OP_MULHU: fin_val = sgn_diff ? prod_neg[2*XLEN-1:XLEN] : hi_q;
            OP_DIV, OP_DIVU:              fin_val = div0_q ? DIV0_QUOT : (sgn_diff ? -lo_q : lo_q);
            default:                      fin_val = a_neg_q ? -hi_q : hi_q;   // REM, REMU
        endcase
    end

    // Next-state and datapath update for IDLE -> CALC -> FIN -> IDLE
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        div0_d   = div0_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mif.start && !mif.flush) begin
                    op_d    = req_op;
                    a_neg_d = req_a_neg;
                    b_neg_d = req_b_neg;
                    div0_d  = (mif.rs2 == '0);
                    mag_a_d = req_a_neg ? -mif.rs1 : mif.rs1;
                    mag_b_d = req_b_neg ? -mif.rs2 : mif.rs2;
                    hi_d    = '0;
                    // mul shifts the multiplier out of lo; div shifts the dividend out
                    lo_d    = req_op[2] ? (req_a_neg ? -mif.rs1 : mif.rs1)
                                        : (req_b_neg ? -mif.rs2 : mif.rs2);
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (mif.flush) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    if (op_q[2]) begin
                        if (add_cout) begin
                            hi_d = add_sum[XLEN-1:0];
                            lo_d = {lo_q[XLEN-2:0], 1'b1};
                        end else begin
                            hi_d = add_a[XLEN-1:0];
                            lo_d = {lo_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        hi_d = add_sum[XLEN:1];
                        lo_d = {add_sum[0], lo_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (!mif.flush) begin
                    result_d = fin_val;
                    done_d   = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            div0_q   <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            div0_q   <= div0_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign mif.busy   = busy_q;
    assign mif.done   = done_q;
    assign mif.result = result_q;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_sequencer
//  Purpose  : Directed self-checking bench for muldiv_sequencer
//  Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_sequencer;

    localparam logic [2:0] C_MUL    = 3'b000;
    localparam logic [2:0] C_MULH   = 3'b001;
    localparam logic [2:0] C_MULHSU = 3'b010;
    localparam logic [2:0] C_MULHU  = 3'b011;
    localparam logic [2:0] C_DIV    = 3'b100;
    localparam logic [2:0] C_DIVU   = 3'b101;
    localparam logic [2:0] C_REM    = 3'b110;
    localparam logic [2:0] C_REMU   = 3'b111;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    muldiv_sequencer_if #(.XLEN(32)) mif ();

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mif   (mif)
    );

    always #5 clk = ~clk;

    // Issue one op (caller sits just after an edge) and wait for done.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int bcnt,
                          output bit to);
        bit got;
        mif.start = 1'b1;
        mif.op    = o;
        mif.rs1   = a;
        mif.rs2   = b;
        @(posedge clk);
        #1;
        mif.start = 1'b0;
        lat  = 0;
        bcnt = (mif.busy === 1'b1) ? 1 : 0;
        got  = 1'b0;
        res  = '0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (mif.done === 1'b1) begin
                got = 1'b1;
                res = mif.result;
            end else if (mif.busy === 1'b1) begin
                bcnt++;
            end
        end
        to = !got;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", mif.busy); end
        checks++;
        if (mif.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", mif.done); end
        checks++;
        if (mif.result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=00000000", mif.result); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul();
        logic [31:0] r; int lat, bc; bit to;
        run_op(C_MUL, 32'd7, 32'd6, r, lat, bc, to);
        checks++;
        if (to || r !== 32'h0000002A) begin failures++; $display("FAIL mul_7x6 got=%h exp=0000002a timeout=%0d", r, to); end
        checks++;
        if (lat !== 33) begin failures++; $display("FAIL mul_latency got=%0d exp=33", lat); end
        checks++;
        if (bc !== 33) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=33", bc); end
    endtask

    task automatic test_mulh();
        logic [31:0] r; int lat, bc; bit to;
        run_op(C_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, bc, to);
        checks++;
        if (to || r !== 32'hFFFFFFFE) begin failures++; $display("FAIL mulhu got=%h exp=fffffffe", r); end
        run_op(C_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, bc, to);
        checks++;
        if (to || r !== 32'h00000000) begin failures++; $display("FAIL mulh got=%h exp=00000000", r); end
        run_op(C_MULHSU, 32'hFFFFFFFF, 32'd2, r, lat, bc, to);
        checks++;
        if (to || r !== 32'hFFFFFFFF) begin failures++; $display("FAIL mulhsu got=%h exp=ffffffff", r); end
        run_op(C_MUL, 32'hFFFFFFFD, 32'd5, r, lat, bc, to);
        checks++;
        if (to || r !== 32'hFFFFFFF1) begin failures++; $display("FAIL mul_neg got=%h exp=fffffff1", r); end
    endtask

    task automatic test_div();
        logic [31:0] r; int lat, bc; bit to;
        run_op(C_DIV, 32'hFFFFFFF9, 32'd2, r, lat, bc, to);
        checks++;
        if (to || r !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_neg got=%h exp=fffffffd", r); end
        run_op(C_REM, 32'hFFFFFFF9, 32'd2, r, lat, bc, to);
        checks++;
        if (to || r !== 32'hFFFFFFFF) begin failures++; $display("FAIL rem_neg got=%h exp=ffffffff", r); end
        run_op(C_DIVU, 32'd100, 32'd7, r, lat, bc, to);
        checks++;
        if (to || r !== 32'd14) begin failures++; $display("FAIL divu got=%h exp=0000000e", r); end
        run_op(C_REMU, 32'd100, 32'd7, r, lat, bc, to);
        checks++;
        if (to || r !== 32'd2) begin failures++; $display("FAIL remu got=%h exp=00000002", r); end
    endtask

    task automatic test_div_edge();
        logic [31:0] r; int lat, bc; bit to;
        run_op(C_DIVU, 32'd5, 32'd0, r, lat, bc, to);
        checks++;
        if (to || r !== 32'hFFFFFFFF) begin failures++; $display("FAIL divu_by0 got=%h exp=ffffffff", r); end
        checks++;
        if (lat !== 33) begin failures++; $display("FAIL div0_latency got=%0d exp=33", lat); end
        run_op(C_REM, 32'd5, 32'd0, r, lat, bc, to);
        checks++;
        if (to || r !== 32'd5) begin failures++; $display("FAIL rem_by0 got=%h exp=00000005", r); end
        run_op(C_DIV, 32'hFFFFFFF9, 32'd0, r, lat, bc, to);
        checks++;
        if (to || r !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_neg_by0 got=%h exp=ffffffff", r); end
        run_op(C_DIV, 32'h80000000, 32'hFFFFFFFF, r, lat, bc, to);
        checks++;
        if (to || r !== 32'h80000000) begin failures++; $display("FAIL div_ovf got=%h exp=80000000", r); end
        run_op(C_REM, 32'h80000000, 32'hFFFFFFFF, r, lat, bc, to);
        checks++;
        if (to || r !== 32'h00000000) begin failures++; $display("FAIL rem_ovf got=%h exp=00000000", r); end
    endtask

    task automatic test_flush();
        logic [31:0] r; int lat, bc; bit to; int dn;
        run_op(C_MUL, 32'd3, 32'd4, r, lat, bc, to);
        checks++;
        if (to || r !== 32'd12) begin failures++; $display("FAIL flush_pre got=%h exp=0000000c", r); end
        mif.start = 1'b1; mif.op = C_MUL; mif.rs1 = 32'd9; mif.rs2 = 32'd9;
        @(posedge clk);
        #1;
        mif.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        mif.flush = 1'b1;
        @(posedge clk);
        #1;
        mif.flush = 1'b0;
        checks++;
        if (mif.busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", mif.busy); end
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (mif.done === 1'b1) dn++;
        end
        checks++;
        if (dn !== 0) begin failures++; $display("FAIL flush_done got=%0d exp=0", dn); end
        checks++;
        if (mif.result !== 32'd12) begin failures++; $display("FAIL flush_result got=%h exp=0000000c", mif.result); end
    endtask

    task automatic test_flush_idle();
        mif.start = 1'b1; mif.flush = 1'b1; mif.op = C_MUL; mif.rs1 = 32'd2; mif.rs2 = 32'd2;
        @(posedge clk);
        #1;
        mif.start = 1'b0; mif.flush = 1'b0;
        checks++;
        if (mif.busy !== 1'b0) begin failures++; $display("FAIL flush_start_idle_busy got=%b exp=0", mif.busy); end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_start_ignored();
        int dn; logic [31:0] r;
        mif.start = 1'b1; mif.op = C_MUL; mif.rs1 = 32'd2; mif.rs2 = 32'd3;
        @(posedge clk);
        #1;
        mif.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        mif.start = 1'b1; mif.rs1 = 32'd9; mif.rs2 = 32'd9;
        @(posedge clk);
        #1;
        mif.start = 1'b0;
        dn = 0;
        r  = '0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #1;
            if (mif.done === 1'b1) begin dn++; r = mif.result; end
        end
        checks++;
        if (dn !== 1) begin failures++; $display("FAIL busy_start_done_count got=%0d exp=1", dn); end
        checks++;
        if (r !== 32'd6) begin failures++; $display("FAIL busy_start_result got=%h exp=00000006", r); end
    endtask

    task automatic test_reset_mid();
        int dn;
        mif.start = 1'b1; mif.op = C_MUL; mif.rs1 = 32'd5; mif.rs2 = 32'd5;
        @(posedge clk);
        #1;
        mif.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (mif.busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", mif.busy); end
        checks++;
        if (mif.result !== 32'h0) begin failures++; $display("FAIL midreset_result got=%h exp=00000000", mif.result); end
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (mif.done === 1'b1) dn++;
        end
        checks++;
        if (dn !== 0) begin failures++; $display("FAIL midreset_done got=%0d exp=0", dn); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, r2; int lat, bc; bit to1, to2;
        run_op(C_DIVU, 32'd100, 32'd7, r1, lat, bc, to1);
        // still inside the done cycle: the next start goes out right away
        run_op(C_MUL, 32'd7, 32'd6, r2, lat, bc, to2);
        checks++;
        if (to1 || r1 !== 32'd14) begin failures++; $display("FAIL b2b_first got=%h exp=0000000e", r1); end
        checks++;
        if (to2 || r2 !== 32'd42) begin failures++; $display("FAIL b2b_second got=%h exp=0000002a", r2); end
        checks++;
        if (lat !== 33 || bc !== 33) begin failures++; $display("FAIL b2b_timing got=lat%0d/busy%0d exp=33/33", lat, bc); end
    endtask

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        checks    = 0;
        failures  = 0;
        mif.start = 1'b0;
        mif.op    = 3'b000;
        mif.rs1   = '0;
        mif.rs2   = '0;
        mif.flush = 1'b0;
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_div_edge();
        test_flush();
        test_flush_idle();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
